// File: rtl/debug_module_cpu_oci_trace_monitor_if.sv
// Trace-frame input and buffered-frame output stream of the OCI trace monitor.
interface debug_module_cpu_oci_trace_monitor_if #(
    parameter int unsigned BUF_W = 30,
    parameter int unsigned CNT_W = 4
);
    logic [BUF_W-1:0]       dct_buffer;
    logic [CNT_W-1:0]       dct_count;
    logic                   dct_valid;
    logic [BUF_W+CNT_W-1:0] out_data;
    logic                   out_valid;
    logic                   out_ready;

    modport master (
        output dct_buffer, dct_count, dct_valid, out_ready,
        input  out_data, out_valid
    );

    modport slave (
        input  dct_buffer, dct_count, dct_valid, out_ready,
        output out_data, out_valid
    );
endinterface

// File: rtl/debug_module_cpu_oci_trace_monitor.sv
// OCI data-cache trace monitor: buffers trace frames in a FIFO, streams them out,
// keeps saturating statistics and sticky error flags, and sequences end-of-test.
module debug_module_cpu_oci_trace_monitor #(
    parameter int unsigned BUF_W     = 30,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned MAX_COUNT = 10,
    parameter int unsigned STAT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    debug_module_cpu_oci_trace_monitor_if.slave bus,
    input  logic                test_ending,
    input  logic                test_has_ended,
    output logic [STAT_W-1:0]   frame_total,
    output logic [STAT_W-1:0]   drop_total,
    output logic                count_err,
    output logic                overflow,
    output logic                done
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned DW = BUF_W + CNT_W;

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t          state, state_next;
    logic [PW-1:0]   wr_ptr, rd_ptr, wr_next, rd_next;
    logic [DW-1:0]   mem [DEPTH];
    logic [DW-1:0]   in_word, head_next;
    logic            flush, push, pop, full, accept, drop, bad_count;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= RUN;
        else       state <= state_next;
    end

    // Next state, FIFO control and next head word
    always_comb begin
        state_next = state;
        flush      = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        accept     = 1'b0;
        drop       = 1'b0;
        wr_next    = wr_ptr;
        rd_next    = rd_ptr;
        in_word    = {bus.dct_count, bus.dct_buffer};
        head_next  = in_word;
        bad_count  = 32'(bus.dct_count) > MAX_COUNT;
        full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

        if (state != DONE) begin
            if (test_has_ended) begin
                flush = 1'b1;
            end else begin
                pop  = bus.out_valid && bus.out_ready;
                push = (state == RUN) && bus.dct_valid;
            end
        end

        // A full FIFO still takes a frame when the head leaves in the same cycle
        accept = push && (!full || pop);
        drop   = push && full && !pop;

        if (flush) begin
            wr_next = '0;
            rd_next = '0;
        end else begin
            if (accept) wr_next = wr_ptr + PW'(1);
            if (pop)    rd_next = rd_ptr + PW'(1);
        end

        case (state)
            RUN: begin
                if (flush)            state_next = DONE;
                else if (test_ending) state_next = DRAIN;
            end
            DRAIN: begin
                if (flush || rd_next == wr_next) state_next = DONE;
            end
            default: state_next = DONE;
        endcase

        // New head is the incoming word when the FIFO is otherwise empty
        if (rd_next != wr_ptr) head_next = mem[rd_next[AW-1:0]];
    end

    // Pointers, registered stream outputs, statistics and flags
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            done          <= 1'b0;
            frame_total   <= '0;
            drop_total    <= '0;
            count_err     <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            wr_ptr        <= wr_next;
            rd_ptr        <= rd_next;
            bus.out_valid <= (state_next != DONE) && (rd_next != wr_next);
            bus.out_data  <= head_next;
            done          <= (state_next == DONE);
            if (accept && frame_total != '1) frame_total <= frame_total + STAT_W'(1);
            if (drop && drop_total != '1)    drop_total  <= drop_total + STAT_W'(1);
            if (push && bad_count)           count_err   <= 1'b1;
            if (drop)                        overflow    <= 1'b1;
        end
    end

    // Storage
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr[AW-1:0]] <= in_word;
    end
endmodule

// File: tb/tb_debug_module_cpu_oci_trace_monitor.sv
// Directed bench for the OCI trace monitor with a queue-based reference model.
module tb_debug_module_cpu_oci_trace_monitor;
    localparam int unsigned BUF_W     = 30;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned MAX_COUNT = 10;
    localparam int unsigned STAT_W    = 16;
    localparam int unsigned DW        = BUF_W + CNT_W;
    localparam int          STAT_MAX  = (1 << STAT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic test_ending = 1'b0;
    logic test_has_ended = 1'b0;
    logic [STAT_W-1:0] frame_total, drop_total;
    logic count_err, overflow, done;

    int checks = 0;
    int failures = 0;
    bit armed = 1'b0;

    debug_module_cpu_oci_trace_monitor_if #(.BUF_W(BUF_W), .CNT_W(CNT_W)) bus ();

    debug_module_cpu_oci_trace_monitor #(
        .BUF_W(BUF_W), .CNT_W(CNT_W), .DEPTH(DEPTH),
        .MAX_COUNT(MAX_COUNT), .STAT_W(STAT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .test_ending(test_ending),
        .test_has_ended(test_has_ended),
        .frame_total(frame_total),
        .drop_total(drop_total),
        .count_err(count_err),
        .overflow(overflow),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: the buffer is a queue of words; frames are counted as they arrive
    logic [DW-1:0] q[$];
    int  m_frames = 0;
    int  m_drops = 0;
    bit  m_err = 1'b0;
    bit  m_ovf = 1'b0;
    bit  m_draining = 1'b0;
    bit  m_done = 1'b0;

    always @(posedge clk) begin
        bit popped, took;
        if (reset) begin
            q.delete();
            m_frames = 0; m_drops = 0; m_err = 1'b0; m_ovf = 1'b0;
            m_draining = 1'b0; m_done = 1'b0;
        end else if (!m_done) begin
            if (test_has_ended) begin
                q.delete();
                m_done = 1'b1;
            end else begin
                popped = (q.size() != 0) && bus.out_ready;
                took = 1'b0;
                if (!m_draining && bus.dct_valid) begin
                    if (int'(bus.dct_count) > int'(MAX_COUNT)) m_err = 1'b1;
                    if (q.size() < DEPTH || popped) begin
                        took = 1'b1;
                        if (m_frames < STAT_MAX) m_frames++;
                    end else begin
                        m_ovf = 1'b1;
                        if (m_drops < STAT_MAX) m_drops++;
                    end
                end
                if (popped) void'(q.pop_front());
                if (took) q.push_back({bus.dct_count, bus.dct_buffer});
                if (m_draining) begin
                    if (q.size() == 0) m_done = 1'b1;
                end else if (test_ending) begin
                    m_draining = 1'b1;
                end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        bit exp_valid;
        if (armed) begin
            exp_valid = !m_done && (q.size() != 0);
            chk("model out_valid", bus.out_valid, exp_valid);
            if (exp_valid) chk("model out_data", bus.out_data, q[0]);
            chk("model frame_total", frame_total, m_frames);
            chk("model drop_total", drop_total, m_drops);
            chk("model count_err", count_err, m_err);
            chk("model overflow", overflow, m_ovf);
            chk("model done", done, m_done);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CNT_W-1:0] c,
                         input logic [BUF_W-1:0] b, input logic r);
        bus.dct_valid  = v;
        bus.dct_count  = c;
        bus.dct_buffer = b;
        bus.out_ready  = r;
    endtask

    initial begin
        logic [DW-1:0] w;
        int n;
        drive(1'b0, '0, '0, 1'b0);
        reset = 1'b1;
        tick();
        armed = 1'b1;
        tick();
        chk("reset out_valid", bus.out_valid, 1'b0);
        chk("reset out_data", bus.out_data, 0);
        chk("reset frame_total", frame_total, 0);
        chk("reset done", done, 1'b0);
        reset = 1'b0;

        // Three frames streamed straight through
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 4'd2, BUF_W'(i), 1'b1);
            tick();
            w = {4'd2, BUF_W'(i)};
            chk("stream head", bus.out_data, w);
            chk("stream valid", bus.out_valid, 1'b1);
        end
        drive(1'b0, '0, '0, 1'b1);
        tick();
        chk("stream empty", bus.out_valid, 1'b0);
        chk("stream frame_total", frame_total, 3);

        // Ten pushes into a stalled FIFO
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 4'd1, BUF_W'(i), 1'b0);
            tick();
        end
        w = {4'd1, 30'h1};
        chk("stall head", bus.out_data, w);
        chk("stall frame_total", frame_total, 11);
        chk("stall drop_total", drop_total, 2);
        chk("stall overflow", overflow, 1'b1);

        // Push and pop together on a full FIFO
        drive(1'b1, 4'd3, 30'h99, 1'b1);
        tick();
        w = {4'd1, 30'h2};
        chk("full swap head", bus.out_data, w);
        chk("full swap frame_total", frame_total, 12);
        chk("full swap drop_total", drop_total, 2);
        drive(1'b0, '0, '0, 1'b1);
        n = 0;
        while (bus.out_valid && n < 20) begin
            n++;
            tick();
        end
        chk("full swap occupancy", n, 8);

        // Out-of-range count is delivered unchanged
        drive(1'b1, 4'd11, 30'h55, 1'b1);
        tick();
        w = {4'd11, 30'h55};
        chk("bad count data", bus.out_data, w);
        chk("bad count flag", count_err, 1'b1);
        drive(1'b0, '0, '0, 1'b1);
        tick();

        // Graceful drain of four frames
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 4'd1, BUF_W'(32'h40 + i), 1'b0);
            tick();
        end
        drive(1'b0, '0, '0, 1'b1);
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        drive(1'b1, 4'd1, 30'h77, 1'b1);
        chk("drain done early", done, 1'b0);
        n = 0;
        while (!done && n < 20) begin
            tick();
            n++;
        end
        chk("drain cycles", n, 3);
        chk("drain frame_total", frame_total, 17);
        tick();
        chk("done holds", done, 1'b1);
        chk("done out_valid", bus.out_valid, 1'b0);
        chk("count_err after done", count_err, 1'b1);

        // Immediate stop flushes buffered frames
        drive(1'b0, '0, '0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset2 frame_total", frame_total, 0);
        chk("reset2 count_err", count_err, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 4'd1, BUF_W'(32'h60 + i), 1'b0);
            tick();
        end
        drive(1'b1, 4'd1, 30'h70, 1'b1);
        test_has_ended = 1'b1;
        tick();
        test_has_ended = 1'b0;
        drive(1'b0, '0, '0, 1'b1);
        chk("flush out_valid", bus.out_valid, 1'b0);
        chk("flush done", done, 1'b1);
        chk("flush frame_total", frame_total, 5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("reset3 done", done, 1'b0);
        chk("reset3 frame_total", frame_total, 0);
        chk("reset3 out_data", bus.out_data, 0);
        chk("reset3 overflow", overflow, 1'b0);

        // Graceful stop with an empty FIFO
        test_ending = 1'b1;
        tick();
        test_ending = 1'b0;
        chk("empty drain step1", done, 1'b0);
        tick();
        chk("empty drain step2", done, 1'b1);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
